masked_affine_stage_pipe: RTL

Parametrised, pipelined masked output stage of the byte-serial AES S-box. It takes a byte split into `SHARES` Boolean shares and refreshes the shares with fresh randomness on entry. It then applies the fixed GF(2) output linear map share-wise and adds the affine constant to share 0 only. Beats move through `STAGES` register stages under a valid/ready handshake. The block sits after the masked inversion gadget and feeds the byte-serial state register.

---
 rtl/masked_aes_pkg.sv | 26 ++
 rtl/masked_pipe_reg.sv | 31 +++
 rtl/masked_affine_stage_pipe.sv | 112 +++++++++++
 3 files changed

// File: rtl/masked_aes_pkg.sv
// Shared definitions for the masked AES S-box output stage: the GF(2) output
// linear map, the default affine constant and the legal parameter ranges.
package masked_aes_pkg;

    localparam int SHARES_MIN = 2;
    localparam int SHARES_MAX = 4;
    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 3;

    localparam logic [7:0] AFFINE_CONST_DEFAULT = 8'hC6;

    // Output linear map, applied to a single share at a time.
    function automatic logic [7:0] lin_map(input logic [7:0] g);
        logic [7:0] o;
        o[7] = g[0] ^ g[2] ^ g[3];
        o[6] = g[1] ^ g[2] ^ g[3] ^ g[4] ^ g[5] ^ g[6];
        o[5] = g[0] ^ g[1] ^ g[2] ^ g[3] ^ g[4] ^ g[5];
        o[4] = g[0] ^ g[1] ^ g[2] ^ g[4];
        o[3] = g[0] ^ g[1] ^ g[2] ^ g[4] ^ g[5] ^ g[6];
        o[2] = g[0] ^ g[2] ^ g[5] ^ g[6];
        o[1] = g[0] ^ g[1] ^ g[2] ^ g[5] ^ g[6];
        o[0] = g[0] ^ g[1] ^ g[3] ^ g[6] ^ g[7];
        return o;
    endfunction

endpackage

// File: rtl/masked_pipe_reg.sv
// One pipeline stage: enable-gated data/last registers plus a valid flag.
// Data only loads when a real beat arrives, so bubbles never toggle it.
module masked_pipe_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         valid_d,
    input  logic [W-1:0] data_d,
    input  logic         last_d,
    output logic         valid_q,
    output logic [W-1:0] data_q,
    output logic         last_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (load) begin
            valid_q <= valid_d;
            if (valid_d) begin
                data_q <= data_d;
                last_q <= last_d;
            end
        end
    end

endmodule

// File: rtl/masked_affine_stage_pipe.sv
// Masked AES S-box output stage: share refresh, share-wise linear map plus
// affine constant on share 0, then a valid/ready register pipeline.
module masked_affine_stage_pipe
    import masked_aes_pkg::*;
#(
    parameter int         SHARES       = 2,
    parameter int         STAGES       = 1,
    parameter logic [7:0] AFFINE_CONST = AFFINE_CONST_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*SHARES-1:0]     in_shares,
    input  logic                    in_mode,
    input  logic [8*(SHARES-1)-1:0] r,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*SHARES-1:0]     out_shares,
    output logic                    out_last
);

    localparam int W = 8 * SHARES;

    if (SHARES < SHARES_MIN || SHARES > SHARES_MAX) begin : g_bad_shares
        $error("masked_affine_stage_pipe: SHARES out of range");
    end
    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
        $error("masked_affine_stage_pipe: STAGES out of range");
    end

    logic [3:0]   cnt_q;
    logic [3:0]   cnt_d;
    logic         accept;
    logic         last_in;
    logic [7:0]   r_sum;
    logic [W-1:0] front_data;

    // Share 0 absorbs every random byte so the sharing stays consistent.
    always_comb begin
        r_sum = '0;
        for (int i = 1; i < SHARES; i++) begin
            r_sum = r_sum ^ r[8*(i-1) +: 8];
        end
    end

    for (genvar gi = 0; gi < SHARES; gi++) begin : g_share
        logic [7:0] refreshed;
        logic [7:0] mapped;
        if (gi == 0) begin : g_first
            assign refreshed = in_shares[7:0] ^ r_sum;
            assign mapped    = lin_map(refreshed) ^ AFFINE_CONST;
        end else begin : g_other
            assign refreshed = in_shares[8*gi +: 8] ^ r[8*(gi-1) +: 8];
            assign mapped    = lin_map(refreshed);
        end
        assign front_data[8*gi +: 8] = in_mode ? mapped : refreshed;
    end

    logic [W-1:0]  st_data [STAGES+1];
    logic [STAGES:0] st_valid;
    logic [STAGES:0] st_last;
    logic [STAGES:1] st_load;

    assign st_data[0]  = front_data;
    assign st_valid[0] = in_valid;
    assign st_last[0]  = last_in;

    // A stage loads when it or any stage downstream of it has a hole, or the
    // sink takes a beat; unrolled this way the ready chain has no feedback.
    for (genvar gi = 1; gi <= STAGES; gi++) begin : g_stage
        assign st_load[gi] = out_ready | ~(&st_valid[STAGES:gi]);

        masked_pipe_reg #(
            .W (W)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (st_load[gi]),
            .valid_d (st_valid[gi-1]),
            .data_d  (st_data[gi-1]),
            .last_d  (st_last[gi-1]),
            .valid_q (st_valid[gi]),
            .data_q  (st_data[gi]),
            .last_q  (st_last[gi])
        );
    end

    assign in_ready = st_load[1];
    assign accept   = in_valid & in_ready;
    assign last_in  = (cnt_q == 4'd15);

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_valid  = st_valid[STAGES];
    assign out_shares = st_data[STAGES];
    assign out_last   = st_last[STAGES];

endmodule
